// File: rtl/ps2_key_event_fifo.sv
// PS/2 set-2 scan-code decoder that queues {code, ext, brk} key events.
// Define PS2_REPEAT_FILTER_EN to drop typematic repeats of the held key.
module ps2_key_event_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int FILTER_SYS = 1,
  parameter int PAUSE_LEN  = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    code,
  input  logic                          tick_done,
  input  logic                          ev_ready,
  input  logic                          ovf_clr,
  output logic                          ev_valid,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_brk,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ev_t;

  state_t     state, state_nx;
  logic [7:0] pcnt, pcnt_nx;
  logic       is_e0, is_f0, is_e1, is_pfx, is_sys;
  logic       ev_push, enq;
  ev_t        ev_in;

  assign is_e0  = code == 8'hE0;
  assign is_f0  = code == 8'hF0;
  assign is_e1  = code == 8'hE1;
  assign is_pfx = is_e0 || is_f0;
  assign is_sys = code == 8'hFA || code == 8'hAA ||
                  code == 8'hEE || code == 8'hFE ||
                  code == 8'h00 || code == 8'hFF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pcnt  <= '0;
    end else begin
      state <= state_nx;
      pcnt  <= pcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pcnt_nx  = pcnt;
    if (tick_done) begin
      unique case (state)
        S_IDLE: begin
          if (is_e0) state_nx = S_EXT;
          else if (is_f0) state_nx = S_BRK;
          else if (is_e1) begin
            state_nx = S_PAUSE;
            pcnt_nx  = PAUSE_LEN[7:0];
          end
        end
        S_EXT: begin
          if (is_f0) state_nx = S_EXT_BRK;
          else if (!is_e0) state_nx = S_IDLE;
        end
        S_BRK: begin
          if (is_e0) state_nx = S_EXT_BRK;
          else if (!is_f0) state_nx = S_IDLE;
        end
        S_EXT_BRK: begin
          if (!is_pfx) state_nx = S_IDLE;
        end
        S_PAUSE: begin
          pcnt_nx = pcnt - 8'd1;
          // <=1 also rescues a zero count rather than wrapping
          if (pcnt <= 8'd1) state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ev_push = 1'b0;
    ev_in   = '0;
    if (tick_done) begin
      unique case (state)
        S_IDLE: begin
          ev_in   = '{code: code, ext: 1'b0, brk: 1'b0};
          ev_push = !is_pfx && !is_e1 &&
                    !(FILTER_SYS != 0 && is_sys);
        end
        S_EXT: begin
          ev_in   = '{code: code, ext: 1'b1, brk: 1'b0};
          ev_push = !is_pfx;
        end
        S_BRK: begin
          ev_in   = '{code: code, ext: 1'b0, brk: 1'b1};
          ev_push = !is_pfx;
        end
        S_EXT_BRK: begin
          ev_in   = '{code: code, ext: 1'b1, brk: 1'b1};
          ev_push = !is_pfx;
        end
        S_PAUSE: begin
          ev_in   = '{code: 8'hE1, ext: 1'b0, brk: 1'b0};
          ev_push = pcnt <= 8'd1;
        end
        default: ev_push = 1'b0;
      endcase
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic [7:0] held_code;
  logic       held_ext, held_vld;
  logic       held_match, rep_hit;

  assign held_match = held_vld && ev_in.code == held_code &&
                      ev_in.ext == held_ext;
  assign rep_hit    = held_match && !ev_in.brk;
  assign enq        = ev_push && !rep_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_code <= '0;
      held_ext  <= 1'b0;
      held_vld  <= 1'b0;
    end else if (ev_push) begin
      if (!ev_in.brk && !rep_hit) begin
        held_code <= ev_in.code;
        held_ext  <= ev_in.ext;
        held_vld  <= 1'b1;
      end else if (ev_in.brk && held_match) begin
        held_vld  <= 1'b0;
      end
    end
  end
`else
  assign enq = ev_push;
`endif

  ev_t         mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        full, do_pop, do_wr, drop;
  ev_t         head;

  assign ev_count = wptr - rptr;
  assign ev_valid = wptr != rptr;
  assign full     = ev_count == (AW+1)'(FIFO_DEPTH);
  assign do_pop   = ev_valid && ev_ready;
  assign do_wr    = enq && (!full || do_pop);
  assign drop     = enq && full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= ev_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      if (drop) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // storage is not reset, so mask the head while empty
  assign head    = mem[rptr[AW-1:0]];
  assign ev_code = ev_valid ? head.code : 8'h00;
  assign ev_ext  = ev_valid && head.ext;
  assign ev_brk  = ev_valid && head.brk;

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Directed bench for ps2_key_event_fifo (DEPTH=4, FILTER_SYS=1).
// Repeat-filter expectations follow PS2_REPEAT_FILTER_EN.
module tb_ps2_key_event_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] code = 8'h00;
  logic       tick_done = 1'b0;
  logic       ev_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext, ev_brk;
  logic [2:0] ev_count;
  logic       overflow;

  int n_pass = 0;
  int n_tot  = 0;

  ps2_key_event_fifo #(
    .FIFO_DEPTH(4),
    .FILTER_SYS(1),
    .PAUSE_LEN(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .code(code),
    .tick_done(tick_done),
    .ev_ready(ev_ready),
    .ovf_clr(ovf_clr),
    .ev_valid(ev_valid),
    .ev_code(ev_code),
    .ev_ext(ev_ext),
    .ev_brk(ev_brk),
    .ev_count(ev_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    code      = b;
    tick_done = 1'b1;
    @(negedge clk);
    tick_done = 1'b0;
  endtask

  task automatic head(input string tag, input logic [7:0] c,
                      input logic x, input logic b);
    chk({tag, ".valid"}, 32'(ev_valid), 32'd1);
    chk({tag, ".code"}, 32'(ev_code), 32'(c));
    chk({tag, ".ext"}, 32'(ev_ext), 32'(x));
    chk({tag, ".brk"}, 32'(ev_brk), 32'(b));
  endtask

  task automatic pop_head(input string tag, input logic [7:0] c,
                          input logic x, input logic b);
    head(tag, c, x, b);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  int nev;

  initial begin
    @(negedge clk);
    chk("rst.valid", 32'(ev_valid), 32'd0);
    chk("rst.count", 32'(ev_count), 32'd0);
    chk("rst.ovf", 32'(overflow), 32'd0);
    chk("rst.code", 32'(ev_code), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // make/break with consumer always ready
    ev_ready = 1'b1;
    send(8'h1C);
    head("mk1C", 8'h1C, 1'b0, 1'b0);
    send(8'hF0);
    chk("popped.valid", 32'(ev_valid), 32'd0);
    send(8'h1C);
    head("bk1C", 8'h1C, 1'b0, 1'b1);
    @(negedge clk);
    chk("drained.count", 32'(ev_count), 32'd0);
    ev_ready = 1'b0;

    // extended make and break
    send(8'hE0);
    send(8'h75);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("ext.count", 32'(ev_count), 32'd2);
    pop_head("ext.mk", 8'h75, 1'b1, 1'b0);
    pop_head("ext.bk", 8'h75, 1'b1, 1'b1);
    chk("ext.empty", 32'(ev_valid), 32'd0);

    // reset mid-prefix discards it
    send(8'hE0);
    send(8'hF0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.count", 32'(ev_count), 32'd0);
    send(8'h29);
    pop_head("midrst.29", 8'h29, 1'b0, 1'b0);

    // pause sequence yields one event only after the last byte
    send(8'hE1);
    send(8'h14);
    send(8'h77);
    send(8'hE1);
    send(8'hF0);
    send(8'h14);
    send(8'hF0);
    chk("pause.pre", 32'(ev_count), 32'd0);
    send(8'h77);
    chk("pause.count", 32'(ev_count), 32'd1);
    pop_head("pause.ev", 8'hE1, 1'b0, 1'b0);

    // system bytes filtered
    send(8'hAA);
    send(8'hFA);
    chk("sys.count", 32'(ev_count), 32'd0);

    // overflow and full behaviour
    send(8'h15);
    send(8'h16);
    send(8'h17);
    send(8'h18);
    chk("full.ovf0", 32'(overflow), 32'd0);
    send(8'h19);
    chk("full.count", 32'(ev_count), 32'd4);
    chk("full.ovf", 32'(overflow), 32'd1);
    head("full.head", 8'h15, 1'b0, 1'b0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovfclr", 32'(overflow), 32'd0);
    ovf_clr = 1'b1;
    send(8'h1B);
    ovf_clr = 1'b0;
    chk("ovf.dropwins", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovfclr2", 32'(overflow), 32'd0);
    ev_ready = 1'b1;
    send(8'h1A);
    ev_ready = 1'b0;
    chk("pushpop.count", 32'(ev_count), 32'd4);
    chk("pushpop.ovf", 32'(overflow), 32'd0);
    pop_head("drain16", 8'h16, 1'b0, 1'b0);
    pop_head("drain17", 8'h17, 1'b0, 1'b0);
    pop_head("drain18", 8'h18, 1'b0, 1'b0);
    pop_head("drain1A", 8'h1A, 1'b0, 1'b0);
    chk("drain.empty", 32'(ev_valid), 32'd0);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    chk("emptypop.count", 32'(ev_count), 32'd0);

    // typematic repeats
    send(8'h1C);
    send(8'h1C);
    send(8'h1C);
    nev = ev_count;
`ifdef PS2_REPEAT_FILTER_EN
    chk("rep.a", 32'(ev_count), 32'd1);
`else
    chk("rep.a", 32'(ev_count), 32'd3);
`endif
    ev_ready = 1'b1;
    repeat (3) @(negedge clk);
    ev_ready = 1'b0;
    chk("rep.a.empty", 32'(ev_valid), 32'd0);
    send(8'hF0);
    send(8'h1C);
    send(8'h1C);
    send(8'h1C);
    nev += ev_count;
`ifdef PS2_REPEAT_FILTER_EN
    chk("rep.b", 32'(ev_count), 32'd2);
    chk("rep.total", 32'(nev), 32'd3);
`else
    chk("rep.b", 32'(ev_count), 32'd3);
    chk("rep.total", 32'(nev), 32'd6);
`endif
    pop_head("rep.bk", 8'h1C, 1'b0, 1'b1);
    pop_head("rep.mk", 8'h1C, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_fifo.md
Name: ps2_key_event_fifo

Overview:
Successor to the single-flag break-code detector. Decodes the PS/2 scan-code set 2 byte stream (make, F0 break, E0 extended, E1 pause) into complete key events {code, ext, brk}. Events are queued in a parametrised FIFO with a valid/ready output handshake. Sits between the PS/2 receiver (code, tick_done) and the keyboard-consumer logic.

Parameters:
FIFO_DEPTH, 4, event queue depth; power of 2, >= 2
FILTER_SYS, 1, 1 = discard controller/system bytes (FA, AA, EE, FE, 00, FF) seen in S_IDLE; 0 = enqueue them as make events
PAUSE_LEN, 7, number of bytes following E1 that belong to the Pause sequence

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
code  in  8  byte from PS/2 receiver, valid when tick_done=1
tick_done  in  1  one-cycle strobe: code holds a new byte
ev_ready  in  1  consumer accepts head event this cycle
ovf_clr  in  1  clears the overflow flag
ev_valid  out  1  FIFO non-empty; head event on ev_code/ev_ext/ev_brk
ev_code  out  8  head event scan code
ev_ext  out  1  head event had the E0 prefix
ev_brk  out  1  head event is a release (F0 seen)
ev_count  out  $clog2(FIFO_DEPTH)+1  number of queued events
overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (async, rst=1): FSM to S_IDLE; FIFO emptied; pause counter 0; ev_valid=0, ev_code=0, ev_ext=0, ev_brk=0, ev_count=0, overflow=0. Reset mid-sequence discards the partial prefix.
- FSM advances only on cycles where tick_done=1; otherwise it holds state.
- S_IDLE: E0 -> S_EXT; F0 -> S_BRK; E1 -> S_PAUSE, counter loaded with PAUSE_LEN; system byte with FILTER_SYS=1 -> dropped, stay; any other byte -> push {code,0,0}, stay.
- S_EXT: F0 -> S_EXT_BRK; E0 -> stay (repeated prefix tolerated); other -> push {code,1,0}, go to S_IDLE.
- S_BRK: F0 -> stay; E0 -> S_EXT_BRK; other -> push {code,0,1}, go to S_IDLE.
- S_EXT_BRK: F0/E0 -> stay; other -> push {code,1,1}, go to S_IDLE.
- S_PAUSE: each byte decrements the counter. The byte that takes it to 0 pushes {8'hE1,0,0} and returns to S_IDLE; earlier bytes push nothing.
- Push latency: event written on the clock edge of the tick_done cycle; ev_valid=1 from the next cycle if the FIFO was empty.
- Pop: on ev_valid && ev_ready the head is removed at the clock edge. Outputs show the new head, or ev_valid=0 if the FIFO is now empty. ev_ready while empty is ignored.
- Full: a push without a same-cycle pop is dropped; overflow<=1. A push with a same-cycle pop when full is accepted and ev_count is unchanged.
- overflow: cleared by ovf_clr=1. A drop in the same cycle as ovf_clr wins, so overflow stays 1.
- ev_count = writes - reads; wrap-safe pointers of width log2(FIFO_DEPTH)+1.
- Head outputs are driven from FIFO storage at the read pointer and are stable while ev_valid && !ev_ready.

Optional Feature:
Macro PS2_REPEAT_FILTER_EN.
- Defined: a held-key register {code, ext, valid}.
  - A make event identical to the held key is not enqueued (typematic repeat suppressed).
  - A non-identical make event updates the held key.
  - A break event matching the held key clears valid.
  - Reset clears valid.
- Not defined: every make, including typematic repeats, is enqueued.

Test Plan:
- Bytes 1C, F0, 1C with ev_ready=1 -> events {1C,0,0} then {1C,0,1}; each ev_valid=1 one cycle after its tick_done.
- Bytes E0, 75, E0, F0, 75 -> events {75,1,0}, {75,1,1}; assert rst after E0 F0 in a second run -> the next byte 29 yields {29,0,0}.
- Pause E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,0,0}, after the 8th byte; bytes AA and FA alone -> no events (FILTER_SYS=1).
- ev_ready=0, 5 make codes 15,16,17,18,19 with DEPTH=4 -> ev_count=4, overflow=1, drain order 15..18; ovf_clr -> overflow=0; push+pop on full -> ev_count stays 4.
- Macro defined: 1C,1C,1C,F0,1C,1C -> events {1C,0,0}, {1C,0,1}, {1C,0,0}. Macro undefined: 5 events.
